// File: rtl/ps2_pkg.sv
// Shared constants and frame-state encoding for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT    = 8'hE0;
  localparam logic [7:0]  PS2_REL    = 8'hF0;
  localparam logic [7:0]  PS2_PAUSE  = 8'hE1;
  localparam logic [7:0]  PAUSE_CODE = 8'h77;
  localparam int unsigned PAUSE_SKIP = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_REL) || (b == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Input conditioning: 2-FF synchronisers on both lines, run-length debounce
// on the clock, and a one-cycle falling-edge event of the filtered clock.
module ps2_filter #(
  parameter int unsigned FILT = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILT + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] run_q, run_d;
  logic          fall_q, fall_d;

  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      // The FILT-th consecutive disagreeing cycle commits the new level.
      if (run_q == CW'(FILT - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        run_d = run_q + CW'(1);
      end
    end
    fall_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      filt_q      <= 1'b1;
      run_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      run_q       <= run_d;
      fall_q      <= fall_d;
    end
  end

  assign data_s = data_sync_q[1];
  assign fall   = fall_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame recovery with parity/stop/timeout checking,
// followed by make/break/extended/pause scancode decoding into key events.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT    = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_pressed,
  output logic       key_strobe
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic data_s;
  logic fall;

  ps2_filter #(
    .FILT(FILT)
  ) u_filter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data_s  (data_s),
    .fall    (fall)
  );

  // Frame receiver
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;

    if (fall || (state_q == ST_IDLE)) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall && !data_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          par_d     = 1'b1;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d = {data_s, shift_q[7:1]};
          par_d   = par_q ^ data_s;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = par_q ^ data_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          // Accumulator seeded with 1 ends at 0 when data+parity ones are odd.
          if (data_s && !par_q) begin
            rx_byte_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fall in the same cycle wins over an expiring timeout.
    if ((state_q != ST_IDLE) && !fall && (tmo_q >= TW'(TIMEOUT - 1))) begin
      rx_err_d = 1'b1;
      state_d  = ST_IDLE;
      tmo_d    = '0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  // Scancode decoder
  logic       ext_q, ext_d;
  logic       rel_q, rel_d;
  logic [2:0] skip_q, skip_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_pressed_q, key_pressed_d;
  logic       key_strobe_q, key_strobe_d;

  always_comb begin
    ext_d         = ext_q;
    rel_d         = rel_q;
    skip_d        = skip_q;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_pressed_d = key_pressed_q;
    key_strobe_d  = 1'b0;

    if (rx_err_q) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end else if (rx_valid_q) begin
      if (skip_q != '0) begin
        skip_d = skip_q - 3'd1;
        if (skip_q == 3'd1) begin
          key_code_d    = PAUSE_CODE;
          key_ext_d     = 1'b1;
          key_pressed_d = 1'b1;
          key_strobe_d  = 1'b1;
          ext_d         = 1'b0;
          rel_d         = 1'b0;
        end
      end else if (rx_byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte_q == PS2_REL) begin
        rel_d = 1'b1;
      end else if (rx_byte_q == PS2_PAUSE) begin
        skip_d = 3'(PAUSE_SKIP);
      end else begin
        key_code_d    = rx_byte_q;
        key_ext_d     = ext_q;
        key_pressed_d = ~rel_q;
        key_strobe_d  = 1'b1;
        ext_d         = 1'b0;
        rel_d         = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_q         <= 1'b0;
      rel_q         <= 1'b0;
      skip_q        <= '0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_pressed_q <= 1'b0;
      key_strobe_q  <= 1'b0;
    end else begin
      ext_q         <= ext_d;
      rel_q         <= rel_d;
      skip_q        <= skip_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_pressed_q <= key_pressed_d;
      key_strobe_q  <= key_strobe_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_valid    = rx_valid_q;
  assign rx_err      = rx_err_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_pressed = key_pressed_q;
  assign key_strobe  = key_strobe_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard bench for ps2_kbd_rx: stimulus pushes expected bytes/events,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_ps2_kbd_rx;

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_REL   = 8'hF0;
  localparam logic [7:0] B_PAUSE = 8'hE1;

  logic       clk_sys;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_pressed;
  logic       key_strobe;

  ps2_kbd_rx #(
    .FILT   (4),
    .TIMEOUT(4096)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_err     (rx_err),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_pressed(key_pressed),
    .key_strobe (key_strobe)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic       err;
    logic [7:0] b;
  } rx_exp_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       pressed;
  } key_exp_t;

  rx_exp_t    rxq[$];
  key_exp_t   kq[$];
  logic [7:0] pend[$];

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned last_fall_cyc = 0;
  int unsigned last_err_cyc  = 0;
  bit          prev_valid    = 1'b0;
  bit          mon_en        = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference decoder: collect bytes since the last event and decide from
  // the whole pending sequence what (if anything) it produces.
  task automatic model_good(input logic [7:0] b);
    int  e1_at;
    bit  has_ext, has_rel;
    rxq.push_back('{err: 1'b0, b: b});
    pend.push_back(b);
    e1_at = -1;
    has_ext = 1'b0;
    has_rel = 1'b0;
    foreach (pend[i]) begin
      if (pend[i] == B_PAUSE && e1_at < 0) e1_at = i;
      if (pend[i] == B_EXT) has_ext = 1'b1;
      if (pend[i] == B_REL) has_rel = 1'b1;
    end
    if (e1_at >= 0) begin
      if (pend.size() - 1 - e1_at == 7) begin
        kq.push_back('{code: 8'h77, ext: 1'b1, pressed: 1'b1});
        pend.delete();
      end
    end else if (b != B_EXT && b != B_REL) begin
      kq.push_back('{code: b, ext: has_ext, pressed: !has_rel});
      pend.delete();
    end
  endtask

  task automatic model_err();
    rxq.push_back('{err: 1'b1, b: 8'h00});
    pend.delete();
  endtask

  always @(negedge clk_sys) begin
    if (reset || !mon_en) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid && rx_err)
        check(1'b0, "valid_err_both", {rx_valid, rx_err}, 2'b00);
      if (rx_err) last_err_cyc = cyc;
      if (rx_valid || rx_err) begin
        if (rxq.size() == 0) begin
          check(1'b0, "rx_unexpected", {rx_err, rx_valid, rx_byte}, 0);
        end else begin
          rx_exp_t e;
          e = rxq.pop_front();
          if (e.err)
            check(rx_err && !rx_valid, "rx_err", {rx_err, rx_valid}, 2'b10);
          else
            check(rx_valid && !rx_err && rx_byte == e.b, "rx_byte",
                  {rx_valid, rx_err, rx_byte}, {1'b1, 1'b0, e.b});
        end
      end
      if (key_strobe) begin
        check(prev_valid, "strobe_latency", prev_valid, 1);
        if (kq.size() == 0) begin
          check(1'b0, "key_unexpected", {key_code, key_ext, key_pressed}, 0);
        end else begin
          key_exp_t k;
          k = kq.pop_front();
          check({key_code, key_ext, key_pressed} == k, "key_event",
                {key_code, key_ext, key_pressed}, k);
        end
      end
      prev_valid = rx_valid;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits,
                           input int half, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (half / 2) tick();
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      if (glitch) begin
        repeat (half / 2) tick();
        ps2_clk = 1'b1;
        repeat (2) tick();
        ps2_clk = 1'b0;
        repeat (half - half / 2 - 2) tick();
      end else begin
        repeat (half) tick();
      end
      ps2_clk = 1'b1;
      if (glitch) begin
        repeat (2) tick();
        ps2_clk = 1'b0;
        repeat (2) tick();
        ps2_clk = 1'b1;
        repeat (half - half / 2 - 4) tick();
      end else begin
        repeat (half - half / 2) tick();
      end
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par,
                           input bit bad_stop, input int half, input bit glitch);
    logic par;
    par = (~^b) ^ bad_par;
    if (bad_par || bad_stop) model_err();
    else model_good(b);
    send_bits({!bad_stop, par, b, 1'b0}, 11, half, glitch);
    repeat (half) tick();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((rxq.size() != 0 || kq.size() != 0) && n < 20000) begin
      tick();
      n++;
    end
    check(rxq.size() == 0 && kq.size() == 0, name,
          rxq.size() + kq.size(), 0);
    repeat (6) tick();
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] b;
    int         r, half;
    int unsigned d;

    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) tick();
    check({rx_byte, rx_valid, rx_err, key_code, key_ext, key_pressed, key_strobe} == '0,
          "reset_outputs",
          {rx_byte, rx_valid, rx_err, key_code, key_ext, key_pressed, key_strobe}, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (10) tick();

    send_byte(8'h1C, 0, 0, 100, 0);
    wait_drain("drain_make");

    send_byte(B_REL, 0, 0, 50, 0);
    send_byte(8'h1C, 0, 0, 50, 0);
    wait_drain("drain_break");

    send_byte(B_EXT, 0, 0, 50, 0);
    send_byte(B_REL, 0, 0, 50, 0);
    send_byte(8'h75, 0, 0, 50, 0);
    send_byte(8'h1C, 0, 0, 50, 0);
    wait_drain("drain_ext_break");

    send_byte(B_EXT, 0, 0, 50, 0);
    send_byte(8'h1C, 1, 0, 50, 0);
    send_byte(8'h75, 0, 0, 50, 0);
    wait_drain("drain_parity_err");

    // Stall after five data bits; expect a timeout error then clean recovery.
    model_err();
    send_bits({2'b11, 8'h1C, 1'b0}, 6, 50, 0);
    repeat (5000) tick();
    d = last_err_cyc - last_fall_cyc;
    check(d >= 4100 && d <= 4106, "timeout_delay", d, 4103);
    send_byte(8'h1C, 0, 0, 50, 0);
    wait_drain("drain_timeout");

    send_byte(8'h1C, 0, 0, 50, 1);
    wait_drain("drain_glitch");

    foreach (pause_seq[i]) send_byte(pause_seq[i], 0, 0, 30, 0);
    wait_drain("drain_pause");

    // Reset mid-frame with an E0 prefix pending.
    send_byte(B_EXT, 0, 0, 30, 0);
    wait_drain("drain_pre_reset");
    send_bits({2'b11, 8'h5A, 1'b0}, 4, 30, 0);
    ps2_clk = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    pend.delete();
    repeat (3) tick();
    check({rx_byte, rx_valid, rx_err, key_code, key_ext, key_pressed, key_strobe} == '0,
          "reset_midframe",
          {rx_byte, rx_valid, rx_err, key_code, key_ext, key_pressed, key_strobe}, 0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    repeat (10) tick();
    send_byte(8'h1C, 0, 0, 30, 0);
    wait_drain("drain_post_reset");

    for (int it = 0; it < 40; it++) begin
      r    = $urandom_range(0, 99);
      half = $urandom_range(6, 20);
      b    = 8'($urandom_range(0, 255));
      if (r < 10) begin
        send_byte(b, 1, 0, half, 0);
      end else if (r < 15) begin
        send_byte(b, 0, 1, half, 0);
      end else if (r < 20) begin
        foreach (pause_seq[i]) send_byte(pause_seq[i], 0, 0, half, 0);
      end else if (r < 35) begin
        send_byte(B_EXT, 0, 0, half, 0);
      end else if (r < 50) begin
        send_byte(B_REL, 0, 0, half, 0);
      end else begin
        while (b == B_EXT || b == B_REL || b == B_PAUSE) b = 8'($urandom_range(0, 255));
        send_byte(b, 0, 0, half, 0);
      end
    end
    wait_drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
